// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day counter chain: BCD digit type and
// binary-to-two-digit BCD conversion used for reset and wrap targets.
package clock_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  // Binary 0..99 to tens/ones BCD digits.
  function automatic bcd2_t to_bcd2(input int unsigned bin);
    bcd2_t r;
    r.tens = bcd_t'(bin / 10);
    r.ones = bcd_t'(bin % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single up/down BCD digit with synchronous reset, force-load and a
// digit-level terminal count (digit at LIMIT when counting up, 0 when down).
module bcd_digit
  import clock_pkg::*;
#(
  parameter bcd_t LIMIT    = bcd_t'(BCD_MAX),
  parameter bcd_t INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             tc
);

  // Digit register: reset > load > step, wrapping between 0 and LIMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= INIT_VAL;
    end else if (load) begin
      digit <= load_val;
    end else if (step) begin
      if (up) begin
        digit <= (digit == LIMIT) ? '0 : digit + 4'd1;
      end else begin
        digit <= (digit == '0) ? LIMIT : digit - 4'd1;
      end
    end
  end

  // Terminal count of this digit alone, in the current direction.
  always_comb begin
    tc = up ? (digit == LIMIT) : (digit == '0);
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with up/down stepping, validated preset load,
// combinational terminal count for same-cycle cascading and a registered
// single-cycle carry pulse on every wrap.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned INIT    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       tc,
  output logic       carry,
  output logic       load_err
);

  if (MODULUS < 2 || MODULUS > 100) begin : g_bad_modulus
    $error("bcd_mod_counter: MODULUS must be within 2..100");
  end
  if (INIT >= MODULUS) begin : g_bad_init
    $error("bcd_mod_counter: INIT must be below MODULUS");
  end

  localparam bcd2_t TOP      = to_bcd2(MODULUS - 1);
  localparam bcd2_t INIT_BCD = to_bcd2(INIT);

  logic [7:0] load_bin;
  logic       load_ok;
  logic       at_top;
  logic       ones_tc;
  logic       tens_tc;
  logic       wrap;
  logic       ones_step;
  logic       tens_step;
  logic       ones_load;
  logic       tens_load;
  bcd_t       ones_val;
  bcd_t       tens_val;

  // Load validation, wrap detection and per-digit control.
  // The wrap is applied as a forced load on both digits so the per-digit
  // stepping never has to know the combined modulus.
  always_comb begin
    load_bin  = 8'(load_tens) * 8'd10 + 8'(load_ones);
    load_ok   = (load_ones <= 4'(BCD_MAX)) && (load_bin < 8'(MODULUS));
    at_top    = ({tens, ones} == TOP);
    // Counting down, both digit terminal counts mean value 0.
    wrap      = en & (up ? at_top : (ones_tc & tens_tc));
    tc        = wrap;
    ones_step = en & ~load & ~wrap;
    tens_step = ones_step & ones_tc;
    ones_load = load ? load_ok : wrap;
    tens_load = load ? load_ok : wrap;
    ones_val  = load ? load_ones : (up ? '0 : TOP.ones);
    tens_val  = load ? load_tens : (up ? '0 : TOP.tens);
  end

  bcd_digit #(
    .LIMIT    (bcd_t'(BCD_MAX)),
    .INIT_VAL (INIT_BCD.ones)
  ) u_ones (
    .clk      (clk),
    .rst      (rst),
    .step     (ones_step),
    .up       (up),
    .load     (ones_load),
    .load_val (ones_val),
    .digit    (ones),
    .tc       (ones_tc)
  );

  bcd_digit #(
    .LIMIT    (TOP.tens),
    .INIT_VAL (INIT_BCD.tens)
  ) u_tens (
    .clk      (clk),
    .rst      (rst),
    .step     (tens_step),
    .up       (up),
    .load     (tens_load),
    .load_val (tens_val),
    .digit    (tens),
    .tc       (tens_tc)
  );

  // Single-cycle status pulses; a load always suppresses the carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= ~load & wrap;
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: directed scenarios on minute/hour fields and a
// two-stage cascade, plus randomized traffic against an integer model.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: MODULUS=60, INIT=45
  logic       a_rst = 1'b0, a_en = 1'b0, a_up = 1'b1, a_load = 1'b0;
  logic [3:0] a_lo = '0, a_lt = '0;
  logic [3:0] a_ones, a_tens;
  logic       a_tc, a_carry, a_err;

  // Instance H: MODULUS=24, INIT=0
  logic       h_rst = 1'b0, h_en = 1'b0, h_up = 1'b1, h_load = 1'b0;
  logic [3:0] h_lo = '0, h_lt = '0;
  logic [3:0] h_ones, h_tens;
  logic       h_tc, h_carry, h_err;

  // Cascade: seconds S drives minutes M through tc
  logic       c_rst = 1'b0, c_up = 1'b1, c_load = 1'b0, s_en = 1'b0;
  logic [3:0] s_lo = '0, s_lt = '0, m_lo = '0, m_lt = '0;
  logic [3:0] s_ones, s_tens, m_ones, m_tens;
  logic       s_tc, s_carry, s_err, m_tc, m_carry, m_err, m_en;
  assign m_en = s_tc;

  bcd_mod_counter #(.MODULUS(60), .INIT(45)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load),
    .load_ones(a_lo), .load_tens(a_lt), .ones(a_ones), .tens(a_tens),
    .tc(a_tc), .carry(a_carry), .load_err(a_err));

  bcd_mod_counter #(.MODULUS(24), .INIT(0)) u_h (
    .clk(clk), .rst(h_rst), .en(h_en), .up(h_up), .load(h_load),
    .load_ones(h_lo), .load_tens(h_lt), .ones(h_ones), .tens(h_tens),
    .tc(h_tc), .carry(h_carry), .load_err(h_err));

  bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_s (
    .clk(clk), .rst(c_rst), .en(s_en), .up(c_up), .load(c_load),
    .load_ones(s_lo), .load_tens(s_lt), .ones(s_ones), .tens(s_tens),
    .tc(s_tc), .carry(s_carry), .load_err(s_err));

  bcd_mod_counter #(.MODULUS(60), .INIT(0)) u_m (
    .clk(clk), .rst(c_rst), .en(m_en), .up(c_up), .load(c_load),
    .load_ones(m_lo), .load_tens(m_lt), .ones(m_ones), .tens(m_tens),
    .tc(m_tc), .carry(m_carry), .load_err(m_err));

  // Reference model: the counter as a plain integer modulo m.
  typedef struct {
    int v;
    bit c;
    bit e;
  } mst_t;

  function automatic mst_t model_next(int m, int init, mst_t s, bit rst, bit load,
                                      bit en, bit up, int lt, int lo);
    mst_t n;
    n   = s;
    n.c = 1'b0;
    n.e = 1'b0;
    if (rst) begin
      n.v = init;
    end else if (load) begin
      if (lo <= 9 && (10 * lt + lo) < m) n.v = 10 * lt + lo;
      else n.e = 1'b1;
    end else if (en) begin
      if (up) begin
        n.c = (s.v == m - 1);
        n.v = (s.v + 1) % m;
      end else begin
        n.c = (s.v == 0);
        n.v = (s.v + m - 1) % m;
      end
    end
    return n;
  endfunction

  function automatic bit model_tc(int m, int v, bit en, bit up);
    return en && (up ? (v == m - 1) : (v == 0));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_load = 1'b1; a_lt = 4'd1; a_lo = 4'd2;
    tick;
    a_load = 1'b0;
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1;
    tick;
    a_rst = 1'b0; a_en = 1'b0;
    checks++; if ({a_tens, a_ones} !== 8'h45) begin failures++; $display("FAIL reset_value got=%h exp=%h", {a_tens, a_ones}, 8'h45); end
    checks++; if (a_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", a_carry); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL reset_load_err got=%b exp=0", a_err); end
  endtask

  task automatic test_up_wrap;
    logic [7:0] ev[3] = '{8'h59, 8'h00, 8'h01};
    bit         ec[3] = '{1'b0, 1'b1, 1'b0};
    bit         et[3] = '{1'b0, 1'b1, 1'b0};
    a_load = 1'b1; a_lt = 4'd5; a_lo = 4'd8;
    tick;
    a_load = 1'b0; a_up = 1'b1;
    checks++; if ({a_tens, a_ones} !== 8'h58) begin failures++; $display("FAIL upwrap_preset got=%h exp=58", {a_tens, a_ones}); end
    for (int i = 0; i < 3; i++) begin
      a_en = 1'b0;
      #1;
      checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL upwrap_tc_en0 step=%0d got=%b exp=0", i, a_tc); end
      a_en = 1'b1;
      #1;
      checks++; if (a_tc !== et[i]) begin failures++; $display("FAIL upwrap_tc step=%0d got=%b exp=%b", i, a_tc, et[i]); end
      tick;
      checks++; if ({a_tens, a_ones} !== ev[i]) begin failures++; $display("FAIL upwrap_value step=%0d got=%h exp=%h", i, {a_tens, a_ones}, ev[i]); end
      checks++; if (a_carry !== ec[i]) begin failures++; $display("FAIL upwrap_carry step=%0d got=%b exp=%b", i, a_carry, ec[i]); end
    end
    a_en = 1'b0;
    tick;
    checks++; if ({a_tens, a_ones, a_carry} !== {8'h01, 1'b0}) begin failures++; $display("FAIL upwrap_hold got=%h/%b exp=01/0", {a_tens, a_ones}, a_carry); end
  endtask

  task automatic test_down_wrap;
    logic [7:0] ev[3] = '{8'h00, 8'h23, 8'h22};
    bit         ec[3] = '{1'b0, 1'b1, 1'b0};
    bit         et[3] = '{1'b0, 1'b1, 1'b0};
    h_load = 1'b1; h_lt = 4'd0; h_lo = 4'd1;
    tick;
    h_load = 1'b0; h_up = 1'b0;
    checks++; if ({h_tens, h_ones} !== 8'h01) begin failures++; $display("FAIL downwrap_preset got=%h exp=01", {h_tens, h_ones}); end
    for (int i = 0; i < 3; i++) begin
      h_en = 1'b1;
      #1;
      checks++; if (h_tc !== et[i]) begin failures++; $display("FAIL downwrap_tc step=%0d got=%b exp=%b", i, h_tc, et[i]); end
      tick;
      checks++; if ({h_tens, h_ones} !== ev[i]) begin failures++; $display("FAIL downwrap_value step=%0d got=%h exp=%h", i, {h_tens, h_ones}, ev[i]); end
      checks++; if (h_carry !== ec[i]) begin failures++; $display("FAIL downwrap_carry step=%0d got=%b exp=%b", i, h_carry, ec[i]); end
    end
    h_en = 1'b0; h_up = 1'b1;
  endtask

  task automatic test_load;
    a_en = 1'b0;
    a_load = 1'b1; a_lt = 4'd3; a_lo = 4'd7;
    tick;
    checks++; if ({a_tens, a_ones, a_err} !== {8'h37, 1'b0}) begin failures++; $display("FAIL load_ok got=%h/%b exp=37/0", {a_tens, a_ones}, a_err); end
    a_lt = 4'd6; a_lo = 4'd0;
    tick;
    checks++; if ({a_tens, a_ones, a_err} !== {8'h37, 1'b1}) begin failures++; $display("FAIL load_range got=%h/%b exp=37/1", {a_tens, a_ones}, a_err); end
    a_load = 1'b0;
    tick;
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL load_err_pulse got=%b exp=0", a_err); end
    a_load = 1'b1; a_lt = 4'd0; a_lo = 4'hA;
    tick;
    checks++; if ({a_tens, a_ones, a_err} !== {8'h37, 1'b1}) begin failures++; $display("FAIL load_bad_ones got=%h/%b exp=37/1", {a_tens, a_ones}, a_err); end
    a_lt = 4'd5; a_lo = 4'd9;
    tick;
    checks++; if ({a_tens, a_ones, a_err} !== {8'h59, 1'b0}) begin failures++; $display("FAIL load_max got=%h/%b exp=59/0", {a_tens, a_ones}, a_err); end
    a_lt = 4'd1; a_lo = 4'd2; a_en = 1'b1; a_up = 1'b1;
    #1;
    checks++; if (a_tc !== 1'b1) begin failures++; $display("FAIL load_tc got=%b exp=1", a_tc); end
    tick;
    a_load = 1'b0; a_en = 1'b0;
    checks++; if ({a_tens, a_ones, a_carry, a_err} !== {8'h12, 2'b00}) begin failures++; $display("FAIL load_over_en got=%h/%b/%b exp=12/0/0", {a_tens, a_ones}, a_carry, a_err); end
  endtask

  task automatic test_cascade;
    c_load = 1'b1; s_lt = 4'd5; s_lo = 4'd9; m_lt = 4'd5; m_lo = 4'd9;
    tick;
    c_load = 1'b0;
    checks++; if ({m_tens, m_ones, s_tens, s_ones} !== 16'h5959) begin failures++; $display("FAIL casc_preset got=%h exp=5959", {m_tens, m_ones, s_tens, s_ones}); end
    s_en = 1'b1; c_up = 1'b1;
    #1;
    checks++; if ({s_tc, m_tc} !== 2'b11) begin failures++; $display("FAIL casc_up_tc got=%b exp=11", {s_tc, m_tc}); end
    tick;
    s_en = 1'b0;
    checks++; if ({m_tens, m_ones, s_tens, s_ones} !== 16'h0000) begin failures++; $display("FAIL casc_up_value got=%h exp=0000", {m_tens, m_ones, s_tens, s_ones}); end
    checks++; if ({s_carry, m_carry} !== 2'b11) begin failures++; $display("FAIL casc_up_carry got=%b exp=11", {s_carry, m_carry}); end
    tick;
    checks++; if ({s_carry, m_carry, m_tens, m_ones, s_tens, s_ones} !== {2'b00, 16'h0000}) begin failures++; $display("FAIL casc_up_after got=%b/%h exp=00/0000", {s_carry, m_carry}, {m_tens, m_ones, s_tens, s_ones}); end
    s_en = 1'b1; c_up = 1'b0;
    #1;
    checks++; if ({s_tc, m_tc} !== 2'b11) begin failures++; $display("FAIL casc_dn_tc got=%b exp=11", {s_tc, m_tc}); end
    tick;
    s_en = 1'b0;
    checks++; if ({m_tens, m_ones, s_tens, s_ones} !== 16'h5959) begin failures++; $display("FAIL casc_dn_value got=%h exp=5959", {m_tens, m_ones, s_tens, s_ones}); end
    checks++; if ({s_carry, m_carry} !== 2'b11) begin failures++; $display("FAIL casc_dn_carry got=%b exp=11", {s_carry, m_carry}); end
    s_en = 1'b1;
    tick;
    s_en = 1'b0;
    checks++; if ({s_carry, m_carry, m_tens, m_ones, s_tens, s_ones} !== {2'b00, 16'h5958}) begin failures++; $display("FAIL casc_dn_nowrap got=%b/%h exp=00/5958", {s_carry, m_carry}, {m_tens, m_ones, s_tens, s_ones}); end
    c_up = 1'b1;
  endtask

  task automatic test_mid_reset;
    a_load = 1'b1; a_lt = 4'd5; a_lo = 4'd9;
    tick;
    a_load = 1'b0;
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1;
    #1;
    checks++; if (a_tc !== 1'b1) begin failures++; $display("FAIL midrst_tc got=%b exp=1", a_tc); end
    tick;
    checks++; if ({a_tens, a_ones, a_carry, a_err} !== {8'h45, 2'b00}) begin failures++; $display("FAIL midrst_wrap got=%h/%b/%b exp=45/0/0", {a_tens, a_ones}, a_carry, a_err); end
    a_en = 1'b0; a_load = 1'b1; a_lt = 4'd6; a_lo = 4'd0;
    tick;
    checks++; if ({a_tens, a_ones, a_err} !== {8'h45, 1'b0}) begin failures++; $display("FAIL midrst_load got=%h/%b exp=45/0", {a_tens, a_ones}, a_err); end
    a_rst = 1'b0; a_load = 1'b0;
    tick;
    checks++; if ({a_tens, a_ones, a_carry, a_err} !== {8'h45, 2'b00}) begin failures++; $display("FAIL midrst_after got=%h/%b/%b exp=45/0/0", {a_tens, a_ones}, a_carry, a_err); end
  endtask

  task automatic test_random;
    mst_t ma, mh;
    bit   eta, eth;
    ma = '{v: 45, c: 1'b0, e: 1'b0};
    mh = '{v: 0, c: 1'b0, e: 1'b0};
    for (int i = 0; i < 500; i++) begin
      a_rst  = (i == 0) || ($urandom_range(31) == 0);
      a_load = ($urandom_range(7) == 0);
      a_en   = ($urandom_range(3) != 0);
      a_up   = 1'($urandom_range(1));
      a_lt   = 4'($urandom_range(6));
      a_lo   = 4'($urandom_range(10));
      h_rst  = (i == 0) || ($urandom_range(31) == 0);
      h_load = ($urandom_range(7) == 0);
      h_en   = ($urandom_range(3) != 0);
      h_up   = 1'($urandom_range(1));
      h_lt   = 4'($urandom_range(3));
      h_lo   = 4'($urandom_range(10));
      eta = model_tc(60, ma.v, a_en, a_up);
      eth = model_tc(24, mh.v, h_en, h_up);
      ma = model_next(60, 45, ma, a_rst, a_load, a_en, a_up, int'(a_lt), int'(a_lo));
      mh = model_next(24, 0, mh, h_rst, h_load, h_en, h_up, int'(h_lt), int'(h_lo));
      #1;
      if (i > 0) begin
        checks++; if (a_tc !== eta) begin failures++; $display("FAIL rnd_a_tc cyc=%0d got=%b exp=%b", i, a_tc, eta); end
        checks++; if (h_tc !== eth) begin failures++; $display("FAIL rnd_h_tc cyc=%0d got=%b exp=%b", i, h_tc, eth); end
      end
      tick;
      checks++; if ({a_tens, a_ones, a_carry, a_err} !== {4'(ma.v / 10), 4'(ma.v % 10), ma.c, ma.e}) begin
        failures++; $display("FAIL rnd_a cyc=%0d got=%h/%b/%b exp=%0d/%b/%b", i, {a_tens, a_ones}, a_carry, a_err, ma.v, ma.c, ma.e);
      end
      checks++; if ({h_tens, h_ones, h_carry, h_err} !== {4'(mh.v / 10), 4'(mh.v % 10), mh.c, mh.e}) begin
        failures++; $display("FAIL rnd_h cyc=%0d got=%h/%b/%b exp=%0d/%b/%b", i, {h_tens, h_ones}, h_carry, h_err, mh.v, mh.c, mh.e);
      end
    end
    a_rst = 1'b0; a_load = 1'b0; a_en = 1'b0;
    h_rst = 1'b0; h_load = 1'b0; h_en = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; h_rst = 1'b1; c_rst = 1'b1;
    tick;
    a_rst = 1'b0; h_rst = 1'b0; c_rst = 1'b0;
    test_reset;
    test_up_wrap;
    test_down_wrap;
    test_load;
    test_cascade;
    test_mid_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised two-digit BCD modulo counter for the clock's time-of-day chain. One instance per field: seconds and minutes with MODULUS=60, hours with MODULUS=24. It adds up/down counting, a synchronous preset-load with validity checking, and a single-cycle carry pulse. It also provides a combinational terminal-count output, so stages cascade in the same cycle without ripple lag.

## Interface
Parameters:
- MODULUS, 60, count range 0..MODULUS-1. Legal values are 2..100; elaboration fails outside this range.
- INIT, 0, value (binary) loaded on reset. Must be < MODULUS.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count-step qualifier (1 Hz tick or upstream tc); one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  in  1  synchronous preset request.
- load_ones  in  4  BCD ones digit to preset.
- load_tens  in  4  BCD tens digit to preset.
- ones  out  4  current ones digit (BCD, 0..9).
- tens  out  4  current tens digit (BCD, 0..(MODULUS-1)/10).
- tc  out  1  combinational: en & (up ? value==MODULUS-1 : value==0).
- carry  out  1  registered single-cycle pulse coincident with a wrap.
- load_err  out  1  registered single-cycle pulse on a rejected load.

## Operation
- value = 10*tens + ones.
- Reset (rst=1 at an edge):
  - ones/tens = BCD of INIT.
  - carry = 0, load_err = 0.
  - All other inputs are ignored that cycle.
- Priority per edge: rst > load > en > hold.
- Load:
  - Accepted if load_ones ≤ 9 and 10*load_tens + load_ones < MODULUS.
  - When accepted, digits take the load values next edge; carry = 0, load_err = 0.
  - When rejected, digits hold; load_err = 1 for one cycle; carry = 0.
  - A simultaneous en is discarded. No step occurs and no carry is produced.
- Count up (en=1, up=1):
  - ones increments. At 9 it returns to 0 and tens increments.
  - At value MODULUS-1, both digits go to 0 and carry = 1 for one cycle.
- Count down (en=1, up=0):
  - ones decrements. At 0 it becomes 9 and tens decrements.
  - At value 0, digits go to BCD(MODULUS-1) and carry = 1 for one cycle.
- Direction change is legal on any cycle. The step uses the up value sampled with en.
- carry and load_err are 0 on every edge where their condition is not met. They are never sticky.
- Digits never leave the legal range. No illegal states are reachable from reset.

## Timing
- Step latency is 1 cycle: en sampled at edge N, new digits visible after edge N.
- carry rises on the same edge on which the digits show the wrapped value, and falls on the next edge.
- tc is combinational from en, up and the digit registers. It carries no internal combinational path from load or rst.
- Cascade rule: the next stage's en = this stage's tc. All stages then step on the same edge.
- Reset asserted mid-count takes effect at the next edge. Any carry pulse in flight is cleared.
- Continuous en=1 steps every cycle, and each wrap produces exactly one carry pulse.

## Structure
- Shared package clock_pkg:
  - Constants BCD_W = 4 and BCD_MAX = 9.
  - Typedef bcd_t (logic [3:0]).
  - Function to_bcd2 (binary 0..99 to two bcd_t), used for INIT and the MODULUS-1 wrap target.
- One sub-module, bcd_digit: a single up/down BCD digit.
  - Parameter LIMIT.
  - Inputs: step, up, load, load value.
  - Outputs: digit, digit-level terminal count.
  - The top instantiates two of them and applies the combined MODULUS wrap override.
- Target size is 150–250 lines of RTL total.

## Test plan
- **Reset:** INIT=45, MODULUS=60. Assert rst for 1 cycle with en=1 → tens=4, ones=5, carry=0, load_err=0 after the edge.
- **Up wrap:** MODULUS=60, count up from 58 with en=1 each cycle.
  - Sequence is 58, 59, 00, 01.
  - carry=1 only in the cycle showing 00.
  - tc=1 only while the value is 59 with en=1.
- **Down wrap:** MODULUS=24, load 01, then count down with en=1.
  - Sequence is 01, 00, 23, 22.
  - carry=1 only in the cycle showing 23.
  - Direct this test at the hour field.
- **Load checks:** MODULUS=60.
  - load 3,7 → 37, load_err=0.
  - load tens=6, ones=0 → value held, load_err pulses once.
  - load ones=A (0xA) → held, load_err pulses.
  - load with en=1 at value 59 → loaded value, carry=0.
- **Cascade:** two instances (60, 60), second en = first tc, preset to 59:59, one en pulse.
  - Both wrap to 00:00 on the same edge, with both carries high for that single cycle.
  - Repeat counting down from 00:00 → 59:59.
- **Mid-operation reset:** rst asserted in the same cycle as a wrap → digits = INIT, carry stays 0, no spurious load_err.
